stream_dispatcher_flushable: RTL and testbench
==============================================

STREAM_DISPATCHER_FLUSHABLE -- requirements
Module: stream_dispatcher_flushable

Interface
REQ-001 SHALL have parameter DATA_W, default 1: payload width in bits.
REQ-002 SHALL have parameter N_OUP, default 2: number of output streams; must be at least 2.
REQ-003 SHALL have parameter DISPATCH, default "rr": "rr" selects outputs by internal round-robin pointer; "sel" routes each beat by inp_sel_i.
REQ-004 SHALL have derived localparam IDX_W = max(1, clog2(N_OUP)).
REQ-005 SHALL have port clk_i, input, 1 bit: single clock; all logic on rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port flush_i, input, 1 bit: synchronous discard of buffered beats.
REQ-008 SHALL have port inp_data_i, input, DATA_W bits: input payload.
REQ-009 SHALL have port inp_sel_i, input, IDX_W bits: destination index; ignored in "rr" mode.
REQ-010 SHALL have port inp_valid_i, input, 1 bit: input valid.
REQ-011 SHALL have port inp_ready_o, output, 1 bit: input ready.
REQ-012 SHALL have port oup_data_o, output, N_OUP x DATA_W bits: per-output payload.
REQ-013 SHALL have port oup_valid_o, output, N_OUP bits: per-output valid.
REQ-014 SHALL have port oup_ready_i, input, N_OUP bits: per-output ready.
REQ-015 SHALL have port err_o, output, 1 bit: one-cycle pulse when an out-of-range selection is dropped.

Function
REQ-016 SHALL buffer accepted beats, each with its destination index, in a 2-entry FIFO with states EMPTY, ONE and TWO.
REQ-017 SHALL define an input handshake as inp_valid_i && inp_ready_o, and an output handshake as oup_valid_o[i] && oup_ready_i[i].
REQ-018 SHALL drive inp_ready_o = (state != TWO) && !flush_i, so inp_ready_o never depends combinationally on oup_ready_i.
REQ-019 SHALL drive oup_valid_o[i] high only when the FIFO is non-empty and the head index equals i; at most one bit of oup_valid_o is high at a time.
REQ-020 SHALL drive oup_data_o[i] with the head payload while oup_valid_o[i] is high, and '0 otherwise.
REQ-021 SHALL keep head payload and head index stable from valid assertion until the output handshake; flush is the only exception.
REQ-022 SHALL present a beat accepted in cycle t on its output at cycle t+1 at the earliest; no combinational input-to-output path.
REQ-023 SHALL sustain 1 beat per cycle when the selected outputs are continuously ready.
REQ-024 SHALL use these state transitions: push only -> +1; pop only -> -1; push and pop in the same cycle -> state unchanged with FIFO order preserved; push is impossible in TWO.
REQ-025 SHALL, in "rr" mode, tag each accepted beat with the pointer value and advance the pointer by 1 per input handshake, wrapping from N_OUP-1 to 0.
REQ-026 SHALL, in "sel" mode, tag each beat with inp_sel_i.
REQ-027 SHALL, in "sel" mode, still accept a beat with inp_sel_i >= N_OUP, but not store it, and pulse err_o for that cycle.
REQ-028 SHALL, while flush_i is high, accept no input, empty the FIFO on the next edge, reset the rr pointer to 0, and suppress err_o.
REQ-029 SHALL let flush_i override any simultaneous output handshake; beats in flight are lost.

Reset
REQ-030 SHALL, while rst_i is high at a clock edge, set the FIFO state to EMPTY and the rr pointer to 0.
REQ-031 SHALL, after reset, drive oup_valid_o = '0, oup_data_o = '0, inp_ready_o = 1 and err_o = 0.
REQ-032 SHALL, on reset mid-transfer, discard buffered beats exactly as flush does.

Structure
REQ-033 SHALL keep the state enum (EMPTY/ONE/TWO) local; no new shared package is required; IDX_W is computed with the common math package helper.
REQ-034 SHALL be one module with no sub-module; the 2-entry buffer is written inline.
REQ-035 SHALL reject any other DISPATCH value, or N_OUP < 2, at elaboration with a fatal error.

Verification
REQ-036 SHALL cover "rr", N_OUP=3: 6 beats A..F with all outputs ready -> A,D on out0; B,E on out1; C,F on out2; one beat per cycle.
REQ-037 SHALL cover "sel": beat 0x5 to sel=1 while oup_ready_i[1]=0 for 4 cycles -> oup_valid_o=3'b010 and data 0x5 held stable; inp_ready_o falls after the 2nd buffered beat.
REQ-038 SHALL cover "sel", N_OUP=3: inp_sel_i=3 -> err_o pulses 1 cycle; no oup_valid_o assertion; the next legal beat is delivered.
REQ-039 SHALL cover a full FIFO (TWO) with flush_i high for 1 cycle -> next cycle oup_valid_o=0, inp_ready_o=1, and the rr pointer restarts at out0.
REQ-040 SHALL cover ONE state with simultaneous push and pop -> state stays ONE, and the output order equals the input order.
REQ-041 SHALL cover rst_i asserted while in TWO -> all outputs at reset values next cycle, with no stale beat emitted afterwards.

Source files
------------

// File: rtl/stream_dispatcher_flushable_pkg.sv
// Shared math helpers for the stream dispatcher.
`timescale 1ns/1ps

package stream_dispatcher_flushable_pkg;

   // Width of an index able to address n items, never narrower than one bit.
   function automatic int idxWidth(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/stream_dispatcher_flushable.sv
// One-to-N stream dispatcher with a two-entry buffer and a synchronous flush.
// Beats are routed by a round-robin pointer ("rr") or by inp_sel_i ("sel").
`timescale 1ns/1ps

module stream_dispatcher_flushable
   import stream_dispatcher_flushable_pkg::*;
#(
   parameter int    DATA_W   = 1,
   parameter int    N_OUP    = 2,
   parameter string DISPATCH = "rr",
   localparam int   IDX_W    = idxWidth(N_OUP)
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          flush_i,
   input  logic [DATA_W-1:0]             inp_data_i,
   input  logic [IDX_W-1:0]              inp_sel_i,
   input  logic                          inp_valid_i,
   output logic                          inp_ready_o,
   output logic [N_OUP-1:0][DATA_W-1:0]  oup_data_o,
   output logic [N_OUP-1:0]              oup_valid_o,
   input  logic [N_OUP-1:0]              oup_ready_i,
   output logic                          err_o
);

   typedef enum logic [1:0] {
      EMPTY,
      ONE,
      TWO
   } fifoState_e;

   localparam bit               IS_RR     = (DISPATCH == "rr");
   localparam logic [IDX_W:0]   N_OUP_EXT = (IDX_W+1)'(N_OUP);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_OUP - 1);

   // Refuse to build with a dispatch mode or output count we cannot honour.
   if (N_OUP < 2 || !(DISPATCH == "rr" || DISPATCH == "sel")) begin : gBadParams
      $fatal(1, "stream_dispatcher_flushable: N_OUP must be >= 2 and DISPATCH \"rr\" or \"sel\"");
   end

   fifoState_e                   state_q, state_d;
   logic [1:0][DATA_W-1:0]       slotData_q, slotData_d;
   logic [1:0][IDX_W-1:0]        slotIdx_q, slotIdx_d;
   logic [IDX_W-1:0]             rrPtr_q, rrPtr_d;

   logic                         inHandshake;
   logic                         selIllegal;
   logic                         push;
   logic                         pop;
   logic                         headReady;
   logic [IDX_W-1:0]             beatIdx;

   // Slot 0 is always the head; slot 1 only holds data in TWO.
   assign inp_ready_o = (state_q != TWO) && !flush_i;
   assign inHandshake = inp_valid_i && inp_ready_o;
   assign selIllegal  = !IS_RR && ({1'b0, inp_sel_i} >= N_OUP_EXT);
   assign beatIdx     = IS_RR ? rrPtr_q : inp_sel_i;
   assign push        = inHandshake && !selIllegal;
   assign err_o       = inHandshake && selIllegal && !rst_i;
   assign pop         = (state_q != EMPTY) && headReady;

   // Look up the ready of whichever output the head beat is addressed to.
   always_comb begin
      headReady = 1'b0;
      for (int i = 0; i < N_OUP; i++) begin
         if (slotIdx_q[0] == IDX_W'(i)) begin
            headReady = oup_ready_i[i];
         end
      end
   end

   // State register together with the buffer slots and the rr pointer.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= EMPTY;
         rrPtr_q    <= '0;
         slotData_q <= '0;
         slotIdx_q  <= '0;
      end else begin
         state_q    <= state_d;
         rrPtr_q    <= rrPtr_d;
         slotData_q <= slotData_d;
         slotIdx_q  <= slotIdx_d;
      end
   end

   // Next-state logic: push/pop bookkeeping, with flush discarding everything.
   always_comb begin
      state_d    = state_q;
      slotData_d = slotData_q;
      slotIdx_d  = slotIdx_q;
      rrPtr_d    = rrPtr_q;

      if (IS_RR && inHandshake) begin
         rrPtr_d = (rrPtr_q == LAST_IDX) ? '0 : rrPtr_q + IDX_W'(1);
      end

      case (state_q)
         EMPTY: begin
            if (push) begin
               slotData_d[0] = inp_data_i;
               slotIdx_d[0]  = beatIdx;
               state_d       = ONE;
            end
         end
         ONE: begin
            if (push && pop) begin
               slotData_d[0] = inp_data_i;
               slotIdx_d[0]  = beatIdx;
            end else if (push) begin
               slotData_d[1] = inp_data_i;
               slotIdx_d[1]  = beatIdx;
               state_d       = TWO;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (pop) begin
               slotData_d[0] = slotData_q[1];
               slotIdx_d[0]  = slotIdx_q[1];
               state_d       = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase

      if (flush_i) begin
         state_d = EMPTY;
         rrPtr_d = '0;
      end
   end

   // Present the head beat on exactly the output it is addressed to.
   always_comb begin
      oup_valid_o = '0;
      oup_data_o  = '0;
      for (int i = 0; i < N_OUP; i++) begin
         if ((state_q != EMPTY) && (slotIdx_q[0] == IDX_W'(i))) begin
            oup_valid_o[i] = 1'b1;
            oup_data_o[i]  = slotData_q[0];
         end
      end
   end

endmodule

// File: tb/tb_stream_dispatcher_flushable.sv
// Bench for stream_dispatcher_flushable: one "rr" and one "sel" instance,
// both with three 8-bit outputs, checked against a queue of expected beats.
`timescale 1ns/1ps

module tb_stream_dispatcher_flushable;

   typedef struct {
      logic [1:0] idx;
      logic [7:0] data;
   } beat_t;

   typedef struct {
      logic [7:0] data;
      logic [1:0] sel;
      logic       expErr;
      logic       expReady;
   } selVec_t;

   logic clk;

   logic             rstRr, flushRr, rrValid, rrInReady, rrErr;
   logic [7:0]       rrData;
   logic [1:0]       rrSel;
   logic [2:0][7:0]  rrDataO;
   logic [2:0]       rrValidO, rrReady;

   logic             rstSel, flushSel, selValid, selInReady, selErr;
   logic [7:0]       selData;
   logic [1:0]       selSel;
   logic [2:0][7:0]  selDataO;
   logic [2:0]       selValidO, selReady;

   beat_t   rrQ[$];
   beat_t   selQ[$];
   selVec_t vecs[8];

   int         total;
   int         bad;
   int         rrStalls;
   logic [1:0] rrPtrModel;

   stream_dispatcher_flushable #(.DATA_W(8), .N_OUP(3), .DISPATCH("rr")) dutRr (
      .clk_i       (clk),
      .rst_i       (rstRr),
      .flush_i     (flushRr),
      .inp_data_i  (rrData),
      .inp_sel_i   (rrSel),
      .inp_valid_i (rrValid),
      .inp_ready_o (rrInReady),
      .oup_data_o  (rrDataO),
      .oup_valid_o (rrValidO),
      .oup_ready_i (rrReady),
      .err_o       (rrErr)
   );

   stream_dispatcher_flushable #(.DATA_W(8), .N_OUP(3), .DISPATCH("sel")) dutSel (
      .clk_i       (clk),
      .rst_i       (rstSel),
      .flush_i     (flushSel),
      .inp_data_i  (selData),
      .inp_sel_i   (selSel),
      .inp_valid_i (selValid),
      .inp_ready_o (selInReady),
      .oup_data_o  (selDataO),
      .oup_valid_o (selValidO),
      .oup_ready_i (selReady),
      .err_o       (selErr)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something wedges.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Pop and compare every output handshake of the rr instance.
   always @(negedge clk) begin
      beat_t e;
      if (!rstRr && !flushRr) begin
         checkOutput("rr_onehot", 32'($countones(rrValidO) <= 1), 32'd1);
         for (int i = 0; i < 3; i++) begin
            if (rrValidO[i] && rrReady[i]) begin
               if (rrQ.size() == 0) begin
                  total++;
                  bad++;
                  $display("[TB] FAIL rr_unexpected: got beat 0x%0h on out%0d expected none", rrDataO[i], i);
               end else begin
                  e = rrQ.pop_front();
                  checkOutput("rr_idx", 32'(i), 32'(e.idx));
                  checkOutput("rr_data", 32'(rrDataO[i]), 32'(e.data));
               end
            end
         end
      end
   end

   // Pop and compare every output handshake of the sel instance.
   always @(negedge clk) begin
      beat_t e;
      if (!rstSel && !flushSel) begin
         checkOutput("sel_onehot", 32'($countones(selValidO) <= 1), 32'd1);
         for (int i = 0; i < 3; i++) begin
            if (selValidO[i] && selReady[i]) begin
               if (selQ.size() == 0) begin
                  total++;
                  bad++;
                  $display("[TB] FAIL sel_unexpected: got beat 0x%0h on out%0d expected none", selDataO[i], i);
               end else begin
                  e = selQ.pop_front();
                  checkOutput("sel_idx", 32'(i), 32'(e.idx));
                  checkOutput("sel_data", 32'(selDataO[i]), 32'(e.data));
               end
            end
         end
      end
   end

   // Offer one beat to the rr instance; leaves valid high for back-to-back use.
   task automatic applyStimulus(input logic [7:0] d);
      int    waits;
      beat_t b;
      rrData  = d;
      rrValid = 1'b1;
      waits   = 0;
      @(negedge clk);
      while (!rrInReady && waits < 50) begin
         waits++;
         @(negedge clk);
      end
      if (!rrInReady) begin
         total++;
         bad++;
         $display("[TB] FAIL rr_accept_timeout: got ready=0 expected ready=1 within 50 cycles");
      end else begin
         b.idx  = rrPtrModel;
         b.data = d;
         rrQ.push_back(b);
         rrPtrModel = (rrPtrModel == 2'd2) ? 2'd0 : rrPtrModel + 2'd1;
      end
      rrStalls += waits;
      @(posedge clk);
      #1;
   endtask

   // Offer one beat to the sel instance; illegal destinations are not expected back.
   task automatic sendSel(input logic [7:0] d, input logic [1:0] s);
      int    waits;
      beat_t b;
      selData  = d;
      selSel   = s;
      selValid = 1'b1;
      waits    = 0;
      @(negedge clk);
      while (!selInReady && waits < 50) begin
         waits++;
         @(negedge clk);
      end
      if (!selInReady) begin
         total++;
         bad++;
         $display("[TB] FAIL sel_accept_timeout: got ready=0 expected ready=1 within 50 cycles");
      end else if (s < 2'd3) begin
         b.idx  = s;
         b.data = d;
         selQ.push_back(b);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0] expValid;

      total = 0;  bad = 0;  rrStalls = 0;  rrPtrModel = 2'd0;
      rstRr = 1'b1;  flushRr = 1'b0;  rrValid = 1'b0;  rrData = '0;  rrSel = '0;  rrReady = 3'b111;
      rstSel = 1'b1; flushSel = 1'b0; selValid = 1'b0; selData = '0; selSel = '0; selReady = 3'b111;

      vecs[0] = '{data: 8'h11, sel: 2'd0, expErr: 1'b0, expReady: 1'b1};
      vecs[1] = '{data: 8'h22, sel: 2'd1, expErr: 1'b0, expReady: 1'b1};
      vecs[2] = '{data: 8'h33, sel: 2'd2, expErr: 1'b0, expReady: 1'b1};
      vecs[3] = '{data: 8'h44, sel: 2'd3, expErr: 1'b1, expReady: 1'b1};
      vecs[4] = '{data: 8'h55, sel: 2'd1, expErr: 1'b0, expReady: 1'b1};
      vecs[5] = '{data: 8'h66, sel: 2'd3, expErr: 1'b1, expReady: 1'b1};
      vecs[6] = '{data: 8'h77, sel: 2'd0, expErr: 1'b0, expReady: 1'b1};
      vecs[7] = '{data: 8'h88, sel: 2'd2, expErr: 1'b0, expReady: 1'b1};

      repeat (2) @(posedge clk);
      #1;
      rstRr  = 1'b0;
      rstSel = 1'b0;

      // Reset values on both instances.
      @(negedge clk);
      checkOutput("rst_rr_valid", 32'(rrValidO), 32'd0);
      checkOutput("rst_rr_data", 32'(rrDataO), 32'd0);
      checkOutput("rst_rr_ready", 32'(rrInReady), 32'd1);
      checkOutput("rst_rr_err", 32'(rrErr), 32'd0);
      checkOutput("rst_sel_valid", 32'(selValidO), 32'd0);
      checkOutput("rst_sel_data", 32'(selDataO), 32'd0);
      checkOutput("rst_sel_ready", 32'(selInReady), 32'd1);
      checkOutput("rst_sel_err", 32'(selErr), 32'd0);
      @(posedge clk);
      #1;

      // Table of single sel-mode beats, including out-of-range destinations.
      foreach (vecs[k]) begin
         selData  = vecs[k].data;
         selSel   = vecs[k].sel;
         selValid = 1'b1;
         @(negedge clk);
         checkOutput("tbl_ready", 32'(selInReady), 32'(vecs[k].expReady));
         checkOutput("tbl_err", 32'(selErr), 32'(vecs[k].expErr));
         if (!vecs[k].expErr) selQ.push_back('{idx: vecs[k].sel, data: vecs[k].data});
         @(posedge clk);
         #1;
         selValid = 1'b0;
         expValid = vecs[k].expErr ? 3'b000 : (3'b001 << vecs[k].sel);
         @(negedge clk);
         checkOutput("tbl_err_pulse_end", 32'(selErr), 32'd0);
         checkOutput("tbl_valid", 32'(selValidO), 32'(expValid));
         @(posedge clk);
         #1;
      end

      // Stalled destination: head held stable, input backs up after two beats.
      selReady = 3'b101;
      sendSel(8'h05, 2'd1);
      sendSel(8'h06, 2'd2);
      selValid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput("stall_valid", 32'(selValidO), 32'b010);
         checkOutput("stall_data1", 32'(selDataO[1]), 32'h05);
         checkOutput("stall_data2", 32'(selDataO[2]), 32'h00);
         checkOutput("stall_ready", 32'(selInReady), 32'd0);
         @(posedge clk);
         #1;
      end
      selReady = 3'b111;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("stall_drained", 32'(selQ.size()), 32'd0);
      @(posedge clk);
      #1;

      // Round-robin streaming A..F with every output ready.
      rrReady  = 3'b111;
      rrStalls = 0;
      for (int k = 0; k < 6; k++) applyStimulus(8'h0A + 8'(k));
      rrValid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("rr_stream_stalls", 32'(rrStalls), 32'd0);
      checkOutput("rr_stream_drained", 32'(rrQ.size()), 32'd0);
      checkOutput("rr_stream_idle", 32'(rrValidO), 32'd0);
      @(posedge clk);
      #1;

      // Push and pop together while holding one beat: order kept, no backpressure.
      applyStimulus(8'h41);
      applyStimulus(8'h42);
      rrValid = 1'b0;
      @(negedge clk);
      checkOutput("pushpop_valid", 32'(rrValidO), 32'b010);
      checkOutput("pushpop_data", 32'(rrDataO[1]), 32'h42);
      checkOutput("pushpop_ready", 32'(rrInReady), 32'd1);
      @(posedge clk);
      #1;

      // Fill the buffer, then flush while a handshake would otherwise happen.
      rrReady = 3'b000;
      applyStimulus(8'h51);
      applyStimulus(8'h52);
      rrValid = 1'b0;
      @(negedge clk);
      checkOutput("full_ready", 32'(rrInReady), 32'd0);
      @(posedge clk);
      #1;
      flushRr = 1'b1;
      rrReady = 3'b111;
      rrValid = 1'b1;
      rrData  = 8'h5F;
      rrQ.delete();
      rrPtrModel = 2'd0;
      @(negedge clk);
      checkOutput("flush_ready", 32'(rrInReady), 32'd0);
      checkOutput("flush_err", 32'(rrErr), 32'd0);
      @(posedge clk);
      #1;
      flushRr = 1'b0;
      rrValid = 1'b0;
      @(negedge clk);
      checkOutput("post_flush_valid", 32'(rrValidO), 32'd0);
      checkOutput("post_flush_ready", 32'(rrInReady), 32'd1);
      @(posedge clk);
      #1;
      applyStimulus(8'h53);
      rrValid = 1'b0;
      @(negedge clk);
      checkOutput("post_flush_out0", 32'(rrValidO), 32'b001);
      repeat (2) @(posedge clk);
      #1;

      // Reset while full: everything returns to reset values, nothing stale emerges.
      rrReady = 3'b000;
      applyStimulus(8'h61);
      applyStimulus(8'h62);
      rrValid = 1'b0;
      rstRr   = 1'b1;
      @(posedge clk);
      #1;
      rstRr = 1'b0;
      rrQ.delete();
      rrPtrModel = 2'd0;
      @(negedge clk);
      checkOutput("mid_rst_valid", 32'(rrValidO), 32'd0);
      checkOutput("mid_rst_data", 32'(rrDataO), 32'd0);
      checkOutput("mid_rst_ready", 32'(rrInReady), 32'd1);
      checkOutput("mid_rst_err", 32'(rrErr), 32'd0);
      rrReady = 3'b111;
      repeat (3) @(posedge clk);
      #1;
      applyStimulus(8'h63);
      rrValid = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_out0", 32'(rrValidO), 32'b001);
      repeat (2) @(posedge clk);

      @(negedge clk);
      checkOutput("final_rr_empty", 32'(rrQ.size()), 32'd0);
      checkOutput("final_sel_empty", 32'(selQ.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
